// File: rtl/sms_core_cycle_ctrl.sv
// Core-memory cycle sequencer: arbitrates CPU / I/O cycle-steal requests and
// runs each grant as one destructive-read + restore/write core cycle.
module sms_core_cycle_ctrl #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 12,
    parameter int CYCLE_LEN = 20,
    parameter int SENSE_T   = 5,
    parameter int IO_STREAK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    input  logic              halt,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mar_load,
    output logic              read_drive,
    output logic              sense_strobe,
    input  logic [DATA_W-1:0] sense_data,
    output logic              write_drive,
    output logic [DATA_W-1:0] inhibit,
    output logic              busy,
    output logic [4:0]        cycle_t
);

    localparam int SW = (IO_STREAK < 1) ? 1 : $clog2(IO_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(IO_STREAK);
    localparam logic [4:0] T_LAST     = 5'(CYCLE_LEN - 1);
    localparam logic [4:0] T_SENSE    = 5'(SENSE_T);
    localparam logic [4:0] T_RD_FIRST = 5'd1;
    localparam logic [4:0] T_RD_LAST  = 5'd8;
    localparam logic [4:0] T_WR_FIRST = 5'd10;
    localparam logic [4:0] T_WR_LAST  = 5'd18;

    typedef enum logic {S_IDLE = 1'b0, S_CYCLE = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [4:0]        r_tick, w_tick_nxt;
    logic              w_grant, w_grant_ok, w_pick_io, w_active;
    logic [SW-1:0]     r_streak;
    logic              r_is_io, r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_restore, r_rdata, r_inhibit;
    logic              r_mar_load, r_read_drive, r_sense_strobe, r_write_drive;
    logic              r_cpu_ack, r_io_ack, r_busy;

    // Arbitration and next state/tick; CPU wins only once the I/O streak is exhausted.
    always_comb begin
        w_grant_ok  = (cpu_req | io_req) & ~halt;
        w_pick_io   = io_req & ~(cpu_req & (r_streak == STREAK_MAX));
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt = S_CYCLE;
                    w_tick_nxt  = 5'd0;
                    w_grant     = 1'b1;
                end else begin
                    w_tick_nxt  = 5'd0;
                end
            end
            S_CYCLE: begin
                if (r_tick == T_LAST) begin
                    w_tick_nxt = 5'd0;
                    if (w_grant_ok) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tick_nxt = r_tick + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = 5'd0;
            end
        endcase
        w_active = (w_state_nxt == S_CYCLE);
    end

    // State and tick register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tick  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Grant latching, streak count, sense capture and read-data update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak   <= '0;
            r_is_io    <= 1'b0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_restore  <= '0;
            r_rdata    <= '0;
        end else if (w_grant) begin
            r_is_io    <= w_pick_io;
            r_we       <= w_pick_io ? io_we : cpu_we;
            r_mem_addr <= w_pick_io ? io_addr : cpu_addr;
            r_restore  <= w_pick_io ? io_wdata : cpu_wdata;
            if (!w_pick_io) begin
                r_streak <= '0;
            end else if (cpu_req) begin
                r_streak <= r_streak + SW'(1);
            end else begin
                r_streak <= r_streak;
            end
        end else if (r_state == S_CYCLE && r_tick == T_SENSE && !r_we) begin
            // Destructive read: what the sense amps saw is what must be restored.
            r_restore <= sense_data;
            r_rdata   <= sense_data;
        end else if (w_active && w_tick_nxt == T_WR_FIRST && r_we) begin
            r_rdata <= r_restore;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Core drivers and acks, decoded from the upcoming tick so they are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mar_load     <= 1'b0;
            r_read_drive   <= 1'b0;
            r_sense_strobe <= 1'b0;
            r_write_drive  <= 1'b0;
            r_inhibit      <= '0;
            r_cpu_ack      <= 1'b0;
            r_io_ack       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_mar_load     <= w_active && (w_tick_nxt == 5'd0);
            r_read_drive   <= w_active && (w_tick_nxt >= T_RD_FIRST) && (w_tick_nxt <= T_RD_LAST);
            r_sense_strobe <= w_active && (w_tick_nxt == T_SENSE);
            r_write_drive  <= w_active && (w_tick_nxt >= T_WR_FIRST) && (w_tick_nxt <= T_WR_LAST);
            if (w_active && (w_tick_nxt >= T_WR_FIRST) && (w_tick_nxt <= T_WR_LAST)) begin
                r_inhibit <= ~r_restore;
            end else begin
                r_inhibit <= '0;
            end
            r_cpu_ack <= w_active && (w_tick_nxt == T_LAST) && !r_is_io;
            r_io_ack  <= w_active && (w_tick_nxt == T_LAST) && r_is_io;
            r_busy    <= w_active;
        end
    end

    assign cpu_ack      = r_cpu_ack;
    assign io_ack       = r_io_ack;
    assign rdata        = r_rdata;
    assign mem_addr     = r_mem_addr;
    assign mar_load     = r_mar_load;
    assign read_drive   = r_read_drive;
    assign sense_strobe = r_sense_strobe;
    assign write_drive  = r_write_drive;
    assign inhibit      = r_inhibit;
    assign busy         = r_busy;
    assign cycle_t      = r_tick;

endmodule

// File: tb/tb_sms_core_cycle_ctrl.sv
// Directed bench for sms_core_cycle_ctrl: per-tick checks of every driver
// against hand-computed cycle timing, arbitration order, halt and reset abort.
module tb_sms_core_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we, halt;
    logic [14:0] cpu_addr, io_addr;
    logic [11:0] cpu_wdata, io_wdata, sense_data;
    logic        cpu_ack, io_ack, mar_load, read_drive, sense_strobe, write_drive, busy;
    logic [11:0] rdata, inhibit;
    logic [14:0] mem_addr;
    logic [4:0]  cycle_t;

    int n_cmp = 0;
    int n_bad = 0;

    sms_core_cycle_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack),
        .halt(halt), .rdata(rdata), .mem_addr(mem_addr), .mar_load(mar_load),
        .read_drive(read_drive), .sense_strobe(sense_strobe), .sense_data(sense_data),
        .write_drive(write_drive), .inhibit(inhibit), .busy(busy), .cycle_t(cycle_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {cycle_t, mar_load, read_drive, sense_strobe, write_drive, busy, cpu_ack, io_ack, inhibit}
    function automatic logic [23:0] obs_vec();
        return {cycle_t, mar_load, read_drive, sense_strobe, write_drive, busy, cpu_ack, io_ack, inhibit};
    endfunction

    // Walks one granted cycle from t=0 to t=19, checking every tick.
    // Returns at the t=19 sample point, before the edge that ends the cycle.
    task automatic check_cycle(input string tag, input logic exp_io, input logic [14:0] exp_addr,
                               input logic [11:0] exp_inh, input logic [11:0] exp_rdata,
                               input logic [11:0] sense_val, input int halt_at);
        logic [23:0] exp;
        logic        wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wd  = (i >= 10 && i <= 18);
            exp = {5'(i), (i == 0), (i >= 1 && i <= 8), (i == 5), wd, 1'b1,
                   (i == 19 && !exp_io), (i == 19 && exp_io), (wd ? exp_inh : 12'h000)};
            chk($sformatf("%s_t%0d", tag, i), {8'h00, obs_vec()}, {8'h00, exp});
            if (i == 0) chk({tag, "_addr"}, {17'h0, mem_addr}, {17'h0, exp_addr});
            if (i == 19) chk({tag, "_rdata"}, {20'h0, rdata}, {20'h0, exp_rdata});
            sense_data = (i == 5) ? sense_val : 12'h000;
            if (i == halt_at) halt = 1'b1;
        end
    endtask

    initial begin
        logic bad_flag;
        reset = 1'b1; halt = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'd0; cpu_wdata = 12'h000;
        io_req = 1'b0; io_we = 1'b0; io_addr = 15'd0; io_wdata = 12'h000;
        sense_data = 12'h000;
        repeat (2) @(negedge clk);
        chk("reset_state", {8'h00, obs_vec()}, 32'h0);
        chk("reset_rdata", {20'h0, rdata}, 32'h0);
        chk("reset_addr", {17'h0, mem_addr}, 32'h0);
        reset = 1'b0;

        // Reset mid-cycle aborts with no ack.
        cpu_we = 1'b0; cpu_addr = 15'd100; cpu_req = 1'b1;
        @(negedge clk);
        chk("abort_t0", {8'h00, obs_vec()}, {8'h00, 5'd0, 7'b1000100, 12'h000});
        repeat (7) @(negedge clk);
        chk("abort_t7", {27'h0, cycle_t}, 32'd7);
        reset = 1'b1;
        #1;
        chk("abort_outs", {8'h00, obs_vec()}, 32'h0);
        chk("abort_addr", {17'h0, mem_addr}, 32'h0);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bad_flag = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (cpu_ack || busy) bad_flag = 1'b1;
        end
        chk("abort_no_ack", {31'h0, bad_flag}, 32'h0);

        // CPU read: inhibit is the complement of what was sensed.
        cpu_we = 1'b0; cpu_addr = 15'd12345; cpu_req = 1'b1;
        check_cycle("cpu_rd", 1'b0, 15'd12345, 12'h5A3, 12'hA5C, 12'hA5C, -1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_rd_idle", {30'h0, busy, cpu_ack}, 32'h0);

        // CPU write: restore comes from wdata, sense is ignored.
        cpu_we = 1'b1; cpu_addr = 15'd19999; cpu_wdata = 12'h03F; cpu_req = 1'b1;
        check_cycle("cpu_wr", 1'b0, 15'd19999, 12'hFC0, 12'h03F, 12'hABC, -1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_wr_idle", {31'h0, busy}, 32'h0);

        // Contention: both held high, order IO IO CPU IO IO CPU back to back.
        cpu_we = 1'b0; cpu_addr = 15'd9; io_we = 1'b1; io_addr = 15'd7; io_wdata = 12'h0F0;
        cpu_req = 1'b1; io_req = 1'b1;
        check_cycle("ct_io1", 1'b1, 15'd7, 12'hF0F, 12'h0F0, 12'h111, -1);
        check_cycle("ct_io2", 1'b1, 15'd7, 12'hF0F, 12'h0F0, 12'h222, -1);
        check_cycle("ct_cpu1", 1'b0, 15'd9, 12'h5A3, 12'hA5C, 12'hA5C, -1);
        check_cycle("ct_io3", 1'b1, 15'd7, 12'hF0F, 12'h0F0, 12'h333, -1);
        check_cycle("ct_io4", 1'b1, 15'd7, 12'hF0F, 12'h0F0, 12'h444, -1);
        check_cycle("ct_cpu2", 1'b0, 15'd9, 12'h3C3, 12'hC3C, 12'hC3C, -1);
        cpu_req = 1'b0; io_req = 1'b0;
        @(negedge clk);
        chk("ct_idle", {31'h0, busy}, 32'h0);

        // Halt at t=3: cycle finishes, then idles until halt clears.
        cpu_req = 1'b1; io_req = 1'b1;
        check_cycle("halt_io", 1'b1, 15'd7, 12'hF0F, 12'h0F0, 12'h000, 3);
        bad_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || cycle_t != 5'd0 || mar_load) bad_flag = 1'b1;
        end
        chk("halt_idle", {31'h0, bad_flag}, 32'h0);
        halt = 1'b0;
        check_cycle("resume_io", 1'b1, 15'd7, 12'hF0F, 12'h0F0, 12'h000, -1);
        io_req = 1'b0;
        check_cycle("resume_cpu", 1'b0, 15'd9, 12'h000, 12'hFFF, 12'hFFF, -1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("resume_idle", {31'h0, busy}, 32'h0);

        // Simultaneous start from IDLE: I/O first, CPU 20 clocks later.
        io_we = 1'b0; io_addr = 15'd321; cpu_addr = 15'd654;
        cpu_req = 1'b1; io_req = 1'b1;
        check_cycle("sim_io", 1'b1, 15'd321, 12'hEDB, 12'h124, 12'h124, -1);
        io_req = 1'b0;
        check_cycle("sim_cpu", 1'b0, 15'd654, 12'hA98, 12'h567, 12'h567, -1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("sim_idle", {31'h0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
